// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state codes, quarter-phase codes and ACK levels for the I2C master.
package i2c_pkg;
  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] START    = 4'd1;
  localparam logic [3:0] ADDR     = 4'd2;
  localparam logic [3:0] ADDR_ACK = 4'd3;
  localparam logic [3:0] WR_BYTE  = 4'd4;
  localparam logic [3:0] WR_ACK   = 4'd5;
  localparam logic [3:0] RD_BYTE  = 4'd6;
  localparam logic [3:0] RD_ACK   = 4'd7;
  localparam logic [3:0] STOP     = 4'd8;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_bit_timer.sv
// i2c_bit_timer: quarter-period divider producing the SCL bit phase and end-of-quarter/bit strobes.
// Define I2C_CLK_STRETCH_EN to hold at Q2 entry while a slave keeps SCL low.
module i2c_bit_timer
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       scl_s,
  input  logic       scl_oe,
  output logic [1:0] quarter,
  output logic       last_q,
  output logic       bit_end
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic hold;
`ifdef I2C_CLK_STRETCH_EN
  assign hold = quarter == Q2 && cnt == '0 && !scl_s && !scl_oe;
`else
  logic unused_stretch;
  assign unused_stretch = scl_s ^ scl_oe;
  assign hold = 1'b0;
`endif
  assign last_q  = cnt == CW'(CLK_DIV - 1);
  assign bit_end = last_q && quarter == Q3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt     <= '0;
      quarter <= Q0;
    end else if (!run) begin
      cnt     <= '0;
      quarter <= Q0;
    end else if (!hold) begin
      cnt <= last_q ? '0 : cnt + 1'b1;
      if (last_q) quarter <= quarter + 1'b1;
    end
endmodule

// File: rtl/i2c_master_seq.sv
// i2c_master_seq: single-master I2C sequencer (START, address, data with ACK, STOP) on open-drain enables.
// Define I2C_CLK_STRETCH_EN to honour slave clock stretching.
module i2c_master_seq
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int LEN_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             wr_req,
  input  logic [7:0]       wr_data,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  input  logic             SCL_In,
  input  logic             SDA_In,
  output logic             scl_oe,
  output logic             sda_oe
);
  logic [3:0] state;
  logic [1:0] q, sda_sync, scl_sync;
  logic [7:0] sr, rsr;
  logic [2:0] bit_cnt;
  logic [LEN_W-1:0] rem;
  logic rw, samp, wr_ld, last_q, bit_end, sample, byte_end, last;
  logic sda_s;
  assign sda_s     = sda_sync[1];
  assign cmd_ready = state == IDLE;
  assign sample    = q == Q2 && last_q;
  assign byte_end  = bit_cnt == 3'd7;
  assign last      = rem == LEN_W'(1);
  i2c_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state != IDLE),
    .scl_s   (scl_sync[1]),
    .scl_oe  (scl_oe),
    .quarter (q),
    .last_q  (last_q),
    .bit_end (bit_end)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sda_sync <= 2'b11;
      scl_sync <= 2'b11;
    end else begin
      sda_sync <= {sda_sync[0], SDA_In};
      scl_sync <= {scl_sync[0], SCL_In};
    end
  assign scl_oe = (state == IDLE || state == START) ? 1'b0 :
                  state == STOP ? q == Q0 : (q == Q0 || q == Q1);
  // The first write bit is driven straight from wr_data while the shift register loads.
  always_comb begin
    sda_oe = 1'b0;
    case (state)
      START:   sda_oe = q == Q2 || q == Q3;
      ADDR:    sda_oe = ~sr[7];
      WR_BYTE: sda_oe = wr_req ? 1'b0 : ~(wr_ld ? wr_data[7] : sr[7]);
      RD_ACK:  sda_oe = ~(last ? NACK : ACK);
      STOP:    sda_oe = q != Q3;
      default: sda_oe = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      rsr      <= '0;
      rem      <= '0;
      rw       <= 1'b0;
      bit_cnt  <= '0;
      samp     <= 1'b0;
      wr_req   <= 1'b0;
      wr_ld    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack_err <= 1'b0;
    end else begin
      wr_req   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      wr_ld    <= wr_req;
      if (sample) samp <= sda_s;
      if (bit_end && (state == ADDR || state == WR_BYTE || state == RD_BYTE)) bit_cnt <= bit_cnt + 1'b1;
      case (state)
        IDLE: if (cmd_valid) begin
          state    <= START;
          sr       <= {cmd_addr, cmd_rw};
          rw       <= cmd_rw;
          rem      <= cmd_len;
          bit_cnt  <= '0;
          busy     <= 1'b1;
          nack_err <= 1'b0;
        end
        START: if (bit_end) state <= ADDR;
        ADDR: if (bit_end) begin
          sr <= {sr[6:0], 1'b0};
          if (byte_end) state <= ADDR_ACK;
        end
        ADDR_ACK: if (bit_end) begin
          if (samp == NACK) begin
            nack_err <= 1'b1;
            state    <= STOP;
          end else if (rem == '0) begin
            state <= STOP;
          end else begin
            state  <= rw ? RD_BYTE : WR_BYTE;
            wr_req <= !rw;
          end
        end
        WR_BYTE: if (wr_ld) begin
          sr <= wr_data;
        end else if (bit_end) begin
          sr <= {sr[6:0], 1'b0};
          if (byte_end) state <= WR_ACK;
        end
        WR_ACK: if (bit_end) begin
          if (samp == NACK) begin
            nack_err <= 1'b1;
            state    <= STOP;
          end else begin
            rem    <= rem - 1'b1;
            state  <= last ? STOP : WR_BYTE;
            wr_req <= !last;
          end
        end
        RD_BYTE: begin
          if (sample) rsr <= {rsr[6:0], sda_s};
          if (bit_end && byte_end) begin
            state    <= RD_ACK;
            rd_valid <= 1'b1;
            rd_data  <= rsr;
          end
        end
        RD_ACK: if (bit_end) begin
          rem   <= rem - 1'b1;
          state <= last ? STOP : RD_BYTE;
        end
        STOP: if (bit_end) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_i2c_master_seq.sv
// tb_i2c_master_seq: directed and random I2C transactions checked by a bus-level slave model and scoreboard.
`timescale 1ns/1ps
module tb_i2c_master_seq;
  localparam int D   = 4;
  localparam int BIT = 4 * D;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0, wr_data = '0;
  logic cmd_ready, wr_req, rd_valid, busy, done, nack_err, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic scl_line, sda_line;
  logic s_low = 1'b0;
  int s_hold = 0;
  int errors = 0, checks = 0;
  logic scl_p = 1'b1, sda_p = 1'b1, ack_v = 1'b1;
  int k = 0, ph = 3, wcount = 0, stops = 0, wr_cnt = 0;
  logic [7:0] cur = '0, rb = '0;
  logic nack_addr = 1'b0, stretch_on = 1'b0;
  int nack_byte = 0;
  logic [7:0] wq[16];
  logic [7:0] rd_q[$], got[$], rd_got[$];
  logic m_acks[$];
  assign scl_line = !(scl_oe || s_hold != 0);
  assign sda_line = !(sda_oe || s_low);
  always #5 clk = ~clk;
  i2c_master_seq #(.CLK_DIV(D), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len), .wr_req(wr_req),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .nack_err(nack_err), .SCL_In(scl_line), .SDA_In(sda_line),
    .scl_oe(scl_oe), .sda_oe(sda_oe)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  // Write-data feeder and read-data collector.
  always @(negedge clk) begin
    if (wr_req) begin
      wr_data = wq[wr_cnt % 16];
      wr_cnt++;
    end
    if (rd_valid) rd_got.push_back(rd_data);
  end
  // Slave: decodes START/STOP and bits on SCL rising, drives ACK/read data after SCL falling.
  always @(negedge clk) begin
    if (s_hold > 0) s_hold--;
    if (scl_p && scl_line && sda_p && !sda_line) begin
      k = 0; ph = 0; wcount = 0; s_low = 1'b0;
    end else if (scl_p && scl_line && !sda_p && sda_line) begin
      stops++; ph = 3; k = 0; s_low = 1'b0;
    end else if (!scl_p && scl_line && ph != 3) begin
      k++;
      if (k <= 8) cur = {cur[6:0], sda_line};
      if (k == 8 && ph != 2) begin
        got.push_back(cur);
        if (ph == 1) wcount++;
      end
      if (k == 9) begin
        ack_v = sda_line;
        k = 0;
        if (ph == 2) m_acks.push_back(ack_v);
        if (ph == 0) ph = cur[0] ? 2 : 1;
      end
    end else if (scl_p && !scl_line && ph != 3) begin
      if (k == 8) s_low = ph == 0 ? !nack_addr : ph == 1 ? (wcount != nack_byte) : 1'b0;
      else if (k == 0) begin
        s_low = 1'b0;
        if (ph == 2 && !ack_v && rd_q.size() > 0) begin
          rb = rd_q.pop_front();
          s_low = !rb[7];
        end
      end else begin
        s_low = ph == 2 && !rb[7-k];
        if (stretch_on && ph == 1 && wcount == 0 && k == 4) s_hold = 2 * D + 20;
      end
    end
    scl_p = scl_line;
    sda_p = sda_line;
  end
  task automatic xfer(input logic [6:0] a, input logic rw, input int len, input int nb,
                      input logic na, input logic rnd, output int dcyc);
    int nbytes, n, bc, st0;
    logic exp_nack;
    logic [7:0] eb[$];
    nbytes   = na ? 0 : (!rw && nb > 0 && nb <= len) ? nb : len;
    exp_nack = na || (!rw && nb > 0 && nb <= len);
    nack_addr = na;
    nack_byte = nb;
    got.delete(); rd_got.delete(); m_acks.delete(); rd_q.delete();
    wr_cnt = 0;
    st0 = stops;
    for (int i = 0; i < len; i++) begin
      if (rnd) wq[i] = 8'($urandom);
      if (rw) rd_q.push_back(wq[i]);
    end
    @(negedge clk);
    cmd_addr = a; cmd_rw = rw; cmd_len = 8'(len); cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 1;
    bc = 0;
    while (!done && n < 3000) begin
      if (busy) bc++;
      @(posedge clk);
      #1 n++;
    end
    dcyc = n;
    chk("done_seen", done, 1);
`ifndef I2C_CLK_STRETCH_EN
    chk("done_cycle", n, BIT * (11 + 9 * nbytes) + 1);
    chk("busy_cycles", bc, BIT * (11 + 9 * nbytes));
`endif
    chk("busy_at_done", busy, 0);
    chk("nack_err", nack_err, exp_nack);
    chk("wr_req_cnt", wr_cnt, rw ? 0 : nbytes);
    chk("stop_seen", stops - st0, 1);
    chk("bus_idle", {scl_line, sda_line}, 2'b11);
    eb.push_back({a, rw});
    if (!rw) for (int i = 0; i < nbytes; i++) eb.push_back(wq[i]);
    chk("tx_count", got.size(), eb.size());
    foreach (eb[i]) if (i < got.size()) chk("tx_byte", got[i], eb[i]);
    chk("rd_count", rd_got.size(), rw ? nbytes : 0);
    chk("mack_count", m_acks.size(), rw ? nbytes : 0);
    if (rw) for (int i = 0; i < nbytes; i++) begin
      if (i < rd_got.size()) chk("rd_byte", rd_got[i], wq[i]);
      if (i < m_acks.size()) chk("master_ack", m_acks[i], i == nbytes - 1);
    end
  endtask
  initial begin
    int c0, c1, len, nb;
    logic rw, na;
    #1;
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_flags", {busy, done, wr_req, rd_valid, nack_err}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wq[0] = 8'hA5; wq[1] = 8'h3C;
    xfer(7'h50, 1'b0, 2, 0, 1'b0, 1'b0, c0);
    wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
    xfer(7'h1D, 1'b1, 3, 0, 1'b0, 1'b0, c0);
    xfer(7'h2A, 1'b0, 0, 0, 1'b1, 1'b1, c0);
    xfer(7'h44, 1'b0, 3, 2, 1'b0, 1'b1, c0);
    @(negedge clk);
    cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_len = 8'd1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    chk("pre_rst_oe", {scl_oe, sda_oe}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_scl_oe", scl_oe, 0);
    chk("arst_sda_oe", sda_oe, 0);
    chk("arst_ready", cmd_ready, 1);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(7'h3B, 1'b0, 1, 0, 1'b0, 1'b1, c0);
    for (int t = 0; t < 10; t++) begin
      rw  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 4);
      na  = $urandom_range(0, 9) == 0;
      nb  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len > 0 ? len : 1) : 0;
      xfer(7'($urandom), rw, len, nb, na, 1'b1, c0);
    end
`ifdef I2C_CLK_STRETCH_EN
    wq[0] = 8'hA5; wq[1] = 8'h3C;
    xfer(7'h50, 1'b0, 2, 0, 1'b0, 1'b0, c0);
    stretch_on = 1'b1;
    xfer(7'h50, 1'b0, 2, 0, 1'b0, 1'b0, c1);
    stretch_on = 1'b0;
    chk("stretch_delta", c1 - c0, 20);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
- Single-master I2C transaction sequencer.
- Accepts one command per handshake (7-bit address, direction, byte count) and generates START, address byte, data bytes with ACK handling, and STOP.
- Drives open-drain pull-down enables for SCL/SDA; the pad-level buffer/inverter stage sits downstream.
- Sits between the host-side register/bus logic and the I2C pads.

Parameters:
- CLK_DIV, 8, clk cycles per SCL quarter-period; legal range >= 4; one bit = 4*CLK_DIV cycles.
- LEN_W, 8, width of the byte-count field.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; accept = cmd_valid & cmd_ready
- cmd_addr  input  7  target slave address
- cmd_rw  input  1  0 = write, 1 = read
- cmd_len  input  LEN_W  data byte count; 0 = address-only probe
- wr_req  output  1  one-cycle pulse requesting the next write byte
- wr_data  input  8  write byte; stable from the cycle after wr_req until that byte's ACK bit
- rd_data  output  8  received byte
- rd_valid  output  1  one-cycle pulse when rd_data is valid
- busy  output  1  high from accept until done
- done  output  1  one-cycle pulse at transaction end
- nack_err  output  1  slave NACKed; valid with done, held until next accept
- SCL_In  input  1  SCL pad level
- SDA_In  input  1  SDA pad level
- scl_oe  output  1  1 = pull SCL low
- sda_oe  output  1  1 = pull SDA low

Behaviour:
- Reset:
  - scl_oe = sda_oe = 0 (bus released).
  - busy, done, wr_req, rd_valid, nack_err = 0; rd_data = 0x00; state = IDLE (cmd_ready = 1).
- Input sync: SDA_In and SCL_In pass through 2-flop synchronizers.
- Bit timing: quarter counter 0..CLK_DIV-1, quarter index Q0..Q3.
  - SCL low in Q0–Q1, released in Q2–Q3.
  - SDA changes only at Q0 entry.
  - Sampling uses the synchronized SDA in the last cycle of Q2.
- Command capture: cmd_* fields are latched at accept; busy rises in the accept cycle +1; nack_err clears at accept.
- States and transitions:
  - IDLE: on accept -> START.
  - START: SCL released all 4 quarters; SDA released Q0–Q1, pulled low Q2–Q3 -> ADDR.
  - ADDR: 8 bits, MSB first, {addr, rw} -> ADDR_ACK.
  - ADDR_ACK: SDA released; sample.
    - NACK: nack_err = 1 -> STOP.
    - ACK with len = 0 -> STOP.
    - ACK with rw = 0 -> WR_BYTE.
    - ACK with rw = 1 -> RD_BYTE.
  - WR_BYTE:
    - wr_req pulses in the first cycle of the state.
    - wr_data is loaded into the shift register in the second cycle; bit 7 is driven from that cycle.
    - 8 bits -> WR_ACK.
  - WR_ACK: sample.
    - NACK: nack_err = 1 -> STOP.
    - Else decrement the remaining count; 0 -> STOP, else -> WR_BYTE.
  - RD_BYTE: SDA released; shift in 8 samples. rd_valid pulses and rd_data updates in the cycle after Q3 of bit 0 ends -> RD_ACK.
  - RD_ACK: master drives ACK (sda_oe = 1) if bytes remain, NACK (released) on the last byte. Remaining = 0 -> STOP, else -> RD_BYTE.
  - STOP: SDA low in Q0–Q2; SCL low in Q0, released Q1–Q3; SDA released at Q3 entry -> IDLE.
- done pulses in the first IDLE cycle after STOP; busy falls in that same cycle.
- Remaining count is LEN_W wide; no wrap, since len = 0 is handled at ADDR_ACK.
- cmd_valid while busy is ignored, because cmd_ready = 0.
- Reset mid-transaction: immediate bus release and return to reset values. No STOP is generated.

Optional Feature:
- I2C_CLK_STRETCH_EN defined:
  - At Q2 entry, if synchronized SCL_In is low while scl_oe = 0, the quarter counter and state hold.
  - Counting resumes the cycle after SCL_In is seen high. Applies to every bit, including START and STOP.
- Undefined: SCL_In is unused and timing is strictly free-running.

Decomposition:
- Package i2c_pkg:
  - state enum (IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP);
  - quarter encoding Q0..Q3;
  - ACK = 0, NACK = 1 constants.
- Sub-module i2c_bit_timer:
  - clk divider and quarter counter with stretch hold;
  - outputs a quarter index plus last_cycle_of_quarter and bit_end strobes.

Test Plan:
- CLK_DIV = 4, write addr 0x50, len 2, data 0xA5, 0x3C, slave ACKs all:
  - SDA bytes 0xA0, 0xA5, 0x3C observed on SCL rising;
  - wr_req pulses twice; done in cycle 465 after accept; nack_err = 0.
- Read addr 0x1D, len 3, slave returns 0x11, 0x22, 0x33:
  - rd_valid ×3 with those values;
  - master ACK, ACK, then NACK (SDA high on 27th data-phase SCL pulse); STOP follows.
- Address-only probe, len 0, slave NACKs address: nack_err = 1 with done, no wr_req, STOP issued, total 16 × 11 = 176 cycles.
- Write len 3, slave NACKs byte 2: exactly 2 wr_req pulses, nack_err = 1, STOP right after WR_ACK.
- rst_n low mid-ADDR: scl_oe = sda_oe = 0 and cmd_ready = 1 asynchronously; a new command after release completes normally.
- I2C_CLK_STRETCH_EN, slave holds SCL low 20 cycles during bit 3 of the data byte: transaction length grows by exactly 20 cycles; data is still correct.
